// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register
// addressing, default data width and arbiter FSM states.
package regfile_wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned WB_DATA_W  = 64;

   localparam logic [REG_ADDR_W-1:0] REG_XZR = 5'd31;

   typedef enum logic {
      NORMAL,
      FORCE_A
   } wb_arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: ALU (A) and load-return (M) valid/ready channels.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = WB_DATA_W
) ();

   logic                  a_valid;
   logic [REG_ADDR_W-1:0] a_reg;
   logic [DATA_W-1:0]     a_data;
   logic                  a_ready;

   logic                  m_valid;
   logic [REG_ADDR_W-1:0] m_reg;
   logic [DATA_W-1:0]     m_data;
   logic                  m_ready;

   modport master (
      output a_valid, a_reg, a_data, m_valid, m_reg, m_data,
      input  a_ready, m_ready
   );

   modport slave (
      input  a_valid, a_reg, a_data, m_valid, m_reg, m_data,
      output a_ready, m_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Counts consecutive refused ALU requests and flags the cycle whose refusal
// reaches STARVE_LIMIT.
module wb_starve_counter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_stall,
   input  logic i_clear,
   output logic o_limit_hit
);

   logic [3:0] r_count;
   logic [4:0] w_next;

   // One extra bit so the compare stays exact for STARVE_LIMIT = 15.
   assign w_next      = {1'b0, r_count} + 5'd1;
   assign o_limit_hit = i_stall & (w_next == 5'(STARVE_LIMIT));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_stall) begin
         r_count <= w_next[3:0];
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU results and
// load returns; loads win unless the ALU has starved for STARVE_LIMIT cycles.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W       = WB_DATA_W,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   regfile_wb_arbiter_if.slave   wb,
   output logic                  REG_WRITE,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0]     writeData,
   output logic                  a_stall,
   output logic                  force_mode
);

   wb_arb_state_t         r_state;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_reg;
   logic [DATA_W-1:0]     r_data;

   logic                  w_a_ready;
   logic                  w_m_ready;
   logic                  w_a_stall;
   logic                  w_force_hit;
   logic                  w_grant;
   logic                  w_commit;
   logic [REG_ADDR_W-1:0] w_reg;
   logic [DATA_W-1:0]     w_data;

   always_comb begin
      w_a_ready = 1'b0;
      w_m_ready = 1'b0;
      if (!RESET) begin
         if (r_state == FORCE_A) begin
            w_a_ready = wb.a_valid;
            w_m_ready = wb.m_valid & ~wb.a_valid;
         end else begin
            w_m_ready = wb.m_valid;
            w_a_ready = wb.a_valid & ~wb.m_valid;
         end
      end
   end

   assign w_a_stall = ~RESET & wb.a_valid & ~w_a_ready;
   assign w_grant   = w_a_ready | w_m_ready;
   assign w_reg     = w_a_ready ? wb.a_reg  : wb.m_reg;
   assign w_data    = w_a_ready ? wb.a_data : wb.m_data;
   // XZR grants complete the handshake but leave the write port untouched.
   assign w_commit  = w_grant & (w_reg != REG_XZR);

   wb_starve_counter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .i_clk      (CLK),
      .i_rst      (RESET),
      .i_stall    (w_a_stall),
      .i_clear    (w_a_ready | ~wb.a_valid),
      .o_limit_hit(w_force_hit)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= NORMAL;
         r_we    <= 1'b0;
         r_reg   <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            NORMAL:  if (w_force_hit) r_state <= FORCE_A;
            FORCE_A: if (w_a_ready || !wb.a_valid) r_state <= NORMAL;
            default: r_state <= NORMAL;
         endcase
         r_we <= w_commit;
         if (w_commit) begin
            r_reg  <= w_reg;
            r_data <= w_data;
         end
      end
   end

   assign wb.a_ready = w_a_ready;
   assign wb.m_ready = w_m_ready;
   assign a_stall    = w_a_stall;
   assign force_mode = (r_state == FORCE_A);
   assign REG_WRITE  = r_we;
   assign write_reg  = r_reg;
   assign writeData  = r_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against a wait-count reference model of the arbiter.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int unsigned LIMIT = 4;

   logic                  CLK = 1'b0;
   logic                  RESET;
   logic                  REG_WRITE;
   logic [REG_ADDR_W-1:0] write_reg;
   logic [WB_DATA_W-1:0]  writeData;
   logic                  a_stall;
   logic                  force_mode;

   regfile_wb_arbiter_if #(.DATA_W(WB_DATA_W)) wb_if ();

   regfile_wb_arbiter #(
      .DATA_W      (WB_DATA_W),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .wb        (wb_if.slave),
      .REG_WRITE (REG_WRITE),
      .write_reg (write_reg),
      .writeData (writeData),
      .a_stall   (a_stall),
      .force_mode(force_mode)
   );

   always #5 CLK = ~CLK;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model: A's consecutive refusals, and the expected write port.
   int unsigned    m_wait = 0;
   bit             e_we   = 1'b0;
   logic [4:0]     e_reg  = '0;
   logic [63:0]    e_data = '0;

   logic obs_a_ready, obs_m_ready, obs_a_stall, obs_force;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with inputs already driven; checks mid-cycle,
   // advances the model, and returns 1 ns after the next rising edge.
   task automatic cycle();
      bit ef, ea, em;
      ef = (m_wait == LIMIT);
      ea = !RESET && wb_if.a_valid && (ef || !wb_if.m_valid);
      em = !RESET && wb_if.m_valid && !(ef && wb_if.a_valid);
      #3;
      obs_a_ready = wb_if.a_ready;
      obs_m_ready = wb_if.m_ready;
      obs_a_stall = a_stall;
      obs_force   = force_mode;
      check_eq("a_ready",    obs_a_ready, ea);
      check_eq("m_ready",    obs_m_ready, em);
      check_eq("a_stall",    obs_a_stall, !RESET && wb_if.a_valid && !ea);
      check_eq("force_mode", obs_force,   ef);
      check_eq("REG_WRITE",  REG_WRITE,   e_we);
      check_eq("write_reg",  write_reg,   e_reg);
      check_eq("writeData",  writeData,   e_data);
      if (RESET) begin
         m_wait = 0; e_we = 1'b0; e_reg = '0; e_data = '0;
      end else begin
         e_we = 1'b0;
         if (ea && wb_if.a_reg != 5'd31) begin
            e_we = 1'b1; e_reg = wb_if.a_reg; e_data = wb_if.a_data;
         end else if (em && wb_if.m_reg != 5'd31) begin
            e_we = 1'b1; e_reg = wb_if.m_reg; e_data = wb_if.m_data;
         end
         m_wait = (wb_if.a_valid && !ea) ? m_wait + 1 : 0;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic set_a(input bit v, input logic [4:0] r, input logic [63:0] d);
      wb_if.a_valid = v; wb_if.a_reg = r; wb_if.a_data = d;
   endtask

   task automatic set_m(input bit v, input logic [4:0] r, input logic [63:0] d);
      wb_if.m_valid = v; wb_if.m_reg = r; wb_if.m_data = d;
   endtask

   initial begin
      int unsigned n_stall;
      bit          granted;

      RESET = 1'b1;
      set_a(1'b0, '0, '0);
      set_m(1'b0, '0, '0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Single A write
      set_a(1'b1, 5'd5, 64'hDEAD_BEEF);
      cycle();
      check_eq("single_a_ready", obs_a_ready, 1'b1);
      set_a(1'b0, '0, '0);
      check_eq("single_we",   REG_WRITE, 1'b1);
      check_eq("single_reg",  write_reg, 5'd5);
      check_eq("single_data", writeData, 64'hDEAD_BEEF);
      cycle();

      // Collision on reg 9: M first, then A
      set_a(1'b1, 5'd9, 64'd1);
      set_m(1'b1, 5'd9, 64'd2);
      cycle();
      set_m(1'b0, '0, '0);
      check_eq("collide_first",  writeData, 64'd2);
      cycle();
      set_a(1'b0, '0, '0);
      check_eq("collide_second", writeData, 64'd1);
      check_eq("collide_reg",    write_reg, 5'd9);

      // XZR discard leaves the write port untouched
      set_m(1'b1, 5'd31, 64'h1234);
      cycle();
      check_eq("xzr_m_ready", obs_m_ready, 1'b1);
      set_m(1'b0, '0, '0);
      check_eq("xzr_we",   REG_WRITE, 1'b0);
      check_eq("xzr_reg",  write_reg, 5'd9);
      check_eq("xzr_data", writeData, 64'd1);
      cycle();

      // Starvation under continuous M traffic
      set_m(1'b1, 5'd2, 64'h22);
      set_a(1'b1, 5'd3, 64'h33);
      n_stall = 0;
      granted = 1'b0;
      for (int i = 0; i < 10 && !granted; i++) begin
         cycle();
         if (obs_a_ready) granted = 1'b1;
         else if (obs_a_stall) n_stall++;
      end
      check_eq("starve_granted", granted, 1'b1);
      check_eq("starve_stalls",  n_stall, LIMIT);
      check_eq("starve_force",   obs_force, 1'b1);
      check_eq("starve_m_block", obs_m_ready, 1'b0);
      set_a(1'b0, '0, '0);
      cycle();
      check_eq("m_resumes",     obs_m_ready, 1'b1);
      check_eq("force_cleared", obs_force, 1'b0);
      set_m(1'b0, '0, '0);
      cycle();

      // Back-to-back alternating A and M, regs 1..8
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) set_a(1'b1, 5'(i + 1), 64'(100 + i));
         else            set_m(1'b1, 5'(i + 1), 64'(200 + i));
         cycle();
         set_a(1'b0, '0, '0);
         set_m(1'b0, '0, '0);
         check_eq("b2b_we",  REG_WRITE, 1'b1);
         check_eq("b2b_reg", write_reg, 5'(i + 1));
      end
      cycle();

      // Reset mid-transfer
      set_a(1'b1, 5'd7, 64'h77);
      RESET = 1'b1;
      cycle();
      check_eq("rst_a_ready", obs_a_ready, 1'b0);
      cycle();
      check_eq("rst_we",    REG_WRITE, 1'b0);
      check_eq("rst_reg",   write_reg, 5'd0);
      check_eq("rst_data",  writeData, 64'd0);
      check_eq("rst_force", force_mode, 1'b0);
      RESET = 1'b0;
      cycle();
      check_eq("grant_after_reset", obs_a_ready, 1'b1);
      set_a(1'b0, '0, '0);
      check_eq("post_rst_reg", write_reg, 5'd7);

      // Random traffic; requests held until their ready is observed
      obs_a_ready = 1'b0;
      obs_m_ready = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (!wb_if.a_valid || obs_a_ready)
            set_a($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         if (!wb_if.m_valid || obs_m_ready)
            set_m($urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         cycle();
      end
      set_a(1'b0, '0, '0);
      set_m(1'b0, '0, '0);
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port (REG_WRITE / write_reg / writeData) between two writeback requesters: the ALU result path (A) and the data-memory load return path (M). Each requester uses a valid/ready handshake. Load returns have priority, and a starvation counter guarantees ALU forward progress. Writes targeting XZR (register 31) are accepted and discarded. The output is registered, so the register file sees exactly one clean write per cycle.

## Interface
- DATA_W, 64, writeback data width
- STARVE_LIMIT, 4, consecutive cycles A may be refused before it is forcibly granted (range 1–15)

- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- a_valid  in  1  ALU writeback request
- a_reg  in  5  ALU destination register (instruction bits 4-0)
- a_data  in  DATA_W  ALU result
- a_ready  out  1  A accepted this cycle (combinational)
- m_valid  in  1  load writeback request
- m_reg  in  5  load destination register
- m_data  in  DATA_W  load data
- m_ready  out  1  M accepted this cycle (combinational)
- REG_WRITE  out  1  registered write enable to the register file
- write_reg  out  5  registered write address
- writeData  out  DATA_W  registered write data
- a_stall  out  1  a_valid & ~a_ready; drives the upstream pipeline stall
- force_mode  out  1  high while the FSM is in FORCE_A (debug visibility)

## Operation
- FSM states:
  - NORMAL (reset state)
  - FORCE_A
- Grant in NORMAL: M has priority.
  - m_ready = m_valid
  - a_ready = a_valid & ~m_valid
- Grant in FORCE_A: A has priority.
  - a_ready = a_valid
  - m_ready = m_valid & ~a_valid
- At most one of a_ready / m_ready is high in any cycle.
- Starve counter (4 bits):
  - increments when a_stall is high
  - clears when a_ready is high or a_valid is low
- Transitions:
  - NORMAL → FORCE_A when a_stall is high and counter+1 == STARVE_LIMIT
  - FORCE_A → NORMAL after any cycle in which a_ready is high, or when a_valid is low
- Accepted transfer: on the edge, write_reg and writeData load the granted request's reg and data.
  - REG_WRITE = 1 unless the granted reg == 5'd31, in which case REG_WRITE = 0 (discard). Handshake completes either way.
- No grant: REG_WRITE = 0; write_reg and writeData hold their previous values.
- Same destination on both requesters in one cycle: only the granted one is written. The loser retries and writes later, so last-granted wins.
- Requesters must hold valid, reg and data stable until their ready is seen.

## Timing
- Request to write: 1 cycle. A request accepted in cycle N appears on REG_WRITE / write_reg / writeData during cycle N+1, and the register file commits it at the end of N+1.
- Throughput: one write per cycle.
- Worst-case A wait under continuous M traffic: STARVE_LIMIT cycles.
- Reset (synchronous; applies even mid-transfer):
  - REG_WRITE = 0, write_reg = 0, writeData = 0
  - FSM = NORMAL, counter = 0, force_mode = 0
  - a_ready, m_ready and a_stall are forced low while RESET is high
  - any request in flight is dropped; requesters must reissue it
- Counter saturation: the counter cannot exceed STARVE_LIMIT, because reaching it forces the grant.

## Structure
- Shared package (e.g. legv8_pkg) holds:
  - REG_XZR = 5'd31
  - REG_ADDR_W = 5
  - DATA_W default 64
  - FSM state enum {NORMAL, FORCE_A}
- One natural sub-module: wb_starve_counter (counter + threshold compare, parameterised by STARVE_LIMIT). Instantiated once.
- Grant logic, FSM and output register stay in the top module.

## Test plan
- Reset mid-transfer: RESET high for 2 cycles while a_valid=1 → REG_WRITE=0, write_reg=0, writeData=0, a_ready=0 and force_mode=0 throughout. First grant occurs in the first cycle after RESET falls.
- Single A write: a_valid=1, a_reg=5, a_data=64'hDEAD_BEEF for one cycle → a_ready=1 that cycle; next cycle REG_WRITE=1, write_reg=5, writeData=64'hDEAD_BEEF.
- Collision: a_valid and m_valid both high, both targeting reg 9, a_data=1, m_data=2 → cycle N+1 writes 2 (M); A stalls then is granted; cycle N+2 writes 1.
- Starvation (STARVE_LIMIT=4): m_valid held high with a_valid=1 → a_stall high for 4 cycles, force_mode=1, then a_ready=1 on cycle 5 and m_ready=0 that cycle; FSM returns to NORMAL and M resumes.
- XZR discard: m_valid=1, m_reg=31, m_data=64'h1234 → m_ready=1; next cycle REG_WRITE=0 and write_reg / writeData unchanged.
- Back-to-back: alternating A and M requests for 8 cycles with distinct regs 1..8 → 8 consecutive cycles with REG_WRITE=1, addresses in grant order, no gaps.
